// File: rtl/uart_pkg.sv
// Shared constants for the serial receive path: default and legal data
// widths, plus the bit-order selector values used by MSB_FIRST.
package uart_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int DATA_WIDTH_MIN     = 5;
  localparam int DATA_WIDTH_MAX     = 9;

  // Bit-order selectors
  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  // Width of a counter that can hold 0..dw+1
  function automatic int count_width(input int dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Bit counter for one serial frame. Counts accepted shift edges and flags
// the edge that delivers the last bit of the frame. The counter wraps to 0
// on that edge. clear and rst both force it back to 0 and suppress
// frame_done.
module rx_bit_counter
  import uart_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign count      = count_reg;
  assign frame_done = shift & ~clear & ~rst & (count_reg == LAST);

  // Next count: clear wins over shift, and the last bit wraps to 0
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (shift) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/rx_deser.sv
// Serial-to-parallel receiver with a valid/ready output register, a sticky
// overrun flag and optional parity checking.
// Build option: define RX_DESER_PARITY_EN to append one parity bit to each
// frame. That bit is checked against PARITY_ODD and is not placed in
// data_out. Without the option, parity_err is tied to 0.
module rx_deser
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int MSB_FIRST  = LSB_FIRST,
  parameter int PARITY_ODD = 0
) (
  input  logic                              rx_clk,
  input  logic                              rst,
  input  logic                              shift,
  input  logic                              serial_in,
  input  logic                              clear,
  input  logic                              data_ready,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              data_valid,
  output logic                              overrun,
  output logic                              parity_err,
  output logic [$clog2(DATA_WIDTH+2)-1:0]   bit_count
);

`ifdef RX_DESER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = DATA_WIDTH + PAR_BITS;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 2);

  // Reject illegal configurations at elaboration time
  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("rx_deser: DATA_WIDTH %0d outside %0d..%0d", DATA_WIDTH, DATA_WIDTH_MIN, DATA_WIDTH_MAX);
  end
  if (MSB_FIRST != LSB_FIRST && MSB_FIRST != uart_pkg::MSB_FIRST) begin : g_bad_order
    $error("rx_deser: MSB_FIRST must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("rx_deser: PARITY_ODD must be 0 or 1");
  end

  logic [CNT_W-1:0]      count;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] sr_reg;
  logic [FRAME_BITS-1:0] sr_fill;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;
  logic                  overrun_reg;
  logic                  load_frame;
  logic                  drop_frame;

  rx_bit_counter #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_counter (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .shift      (shift),
    .clear      (clear),
    .count      (count),
    .frame_done (frame_done)
  );

  // sr_fill is the shift register with the current serial bit merged in at
  // the slot for received bit index gi. The slot map is a permutation, so
  // every bit of sr_fill has exactly one driver.
  for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_slot
    localparam int POS = (MSB_FIRST != 0 && gi < DATA_WIDTH) ? DATA_WIDTH - 1 - gi : gi;
    assign sr_fill[POS] = (count == CNT_W'(gi)) ? serial_in : sr_reg[POS];
  end

  // A completed frame is kept unless an unconsumed one is still held
  assign load_frame = frame_done & (~data_valid_reg | data_ready);
  assign drop_frame = frame_done & data_valid_reg & ~data_ready;

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign overrun    = overrun_reg;
  assign bit_count  = count;

  // Assembly register, output register, handshake and overrun flag
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      sr_reg         <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (clear || frame_done) begin
        sr_reg <= '0;
      end else if (shift) begin
        sr_reg <= sr_fill;
      end

      if (load_frame) begin
        data_out_reg   <= sr_fill[DATA_WIDTH-1:0];
        data_valid_reg <= 1'b1;
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end

      if (clear) begin
        overrun_reg <= 1'b0;
      end else if (drop_frame) begin
        overrun_reg <= 1'b1;
      end
    end
  end

`ifdef RX_DESER_PARITY_EN
  logic parity_reg;
  logic parity_calc;

  assign parity_calc = (^sr_fill[DATA_WIDTH-1:0]) ^ sr_fill[DATA_WIDTH] ^ (PARITY_ODD != 0);
  assign parity_err  = parity_reg;

  // Parity status follows the frame held in data_out
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (load_frame) begin
      parity_reg <= parity_calc;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_deser.sv
// Bench for rx_deser: two instances (LSB-first and MSB-first) share one
// input stream. A frame-level model predicts every output each cycle, and
// directed literal checks pin the model to hand-computed values.
module tb_rx_deser;

`ifdef RX_DESER_PARITY_EN
  localparam int DW = 7;
  localparam int FB = 8;
`else
  localparam int DW = 8;
  localparam int FB = 8;
`endif
  localparam int CW   = $clog2(DW + 2);
  localparam int PODD = 0;

  logic rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  logic rst = 1'b1, shift = 1'b0, serial_in = 1'b0, clear = 1'b0, data_ready = 1'b0;

  logic [DW-1:0] dout  [2];
  logic          valid [2];
  logic          ovr   [2];
  logic          perr  [2];
  logic [CW-1:0] bcnt  [2];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    rx_deser #(
      .DATA_WIDTH (DW),
      .MSB_FIRST  (gi),
      .PARITY_ODD (PODD)
    ) u_dut (
      .rx_clk     (rx_clk),
      .rst        (rst),
      .shift      (shift),
      .serial_in  (serial_in),
      .clear      (clear),
      .data_ready (data_ready),
      .data_out   (dout[gi]),
      .data_valid (valid[gi]),
      .overrun    (ovr[gi]),
      .parity_err (perr[gi]),
      .bit_count  (bcnt[gi])
    );
  end

  // Model state: received bits of the current frame in arrival order
  logic [15:0]   m_bits  = '0;
  int            m_n     = 0;
  logic [DW-1:0] m_out [2] = '{default: '0};
  logic          m_valid = 1'b0;
  logic          m_ovr   = 1'b0;
  logic          m_perr  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Received bit k goes to data bit k, or DW-1-k when MSB-first
  function automatic logic [DW-1:0] assemble(input logic [15:0] b, input int msb);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < DW; k++) begin
      if (((b >> k) & 16'd1) != 16'd0) w = w | (DW'(1) << ((msb != 0) ? DW - 1 - k : k));
    end
    return w;
  endfunction

  task automatic model_step();
    bit done;
    done = 1'b0;
    if (rst) begin
      m_bits = '0; m_n = 0; m_out[0] = '0; m_out[1] = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      if (clear) begin
        m_bits = '0; m_n = 0;
      end else if (shift) begin
        m_bits = m_bits | (16'(serial_in) << m_n);
        m_n++;
        if (m_n == FB) begin
          done = 1'b1; m_n = 0;
        end
      end
      if (done) begin
        if (m_valid && !data_ready) begin
          m_ovr = 1'b1;
        end else begin
          m_valid  = 1'b1;
          m_out[0] = assemble(m_bits, 0);
          m_out[1] = assemble(m_bits, 1);
`ifdef RX_DESER_PARITY_EN
          m_perr   = (^m_bits[FB-1:0]) ^ (PODD != 0);
`else
          m_perr   = 1'b0;
`endif
        end
        m_bits = '0;
      end else if (m_valid && data_ready) begin
        m_valid = 1'b0;
      end
      if (clear) m_ovr = 1'b0;
    end
  endtask

  // Model advances on each rising edge using the same inputs the DUT samples
  initial forever begin
    @(posedge rx_clk);
    model_step();
  end

  // Compare all outputs of both instances against the model every cycle
  initial forever begin
    @(negedge rx_clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("data_out[%0d]", i),   int'(dout[i]),  int'(m_out[i]));
      check($sformatf("data_valid[%0d]", i), int'(valid[i]), int'(m_valid));
      check($sformatf("overrun[%0d]", i),    int'(ovr[i]),   int'(m_ovr));
      check($sformatf("parity_err[%0d]", i), int'(perr[i]),  int'(m_perr));
      check($sformatf("bit_count[%0d]", i),  int'(bcnt[i]),  m_n);
    end
  end

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Send n bits, bit k of 'bits' first-to-last; optionally raise data_ready
  // on the edge that carries the last bit
  task automatic send(input logic [15:0] bits, input int n, input logic ready_last);
    for (int k = 0; k < n; k++) begin
      shift      = 1'b1;
      serial_in  = bits[k];
      data_ready = (k == n - 1) && ready_last;
      tick();
    end
    shift      = 1'b0;
    serial_in  = 1'b0;
    data_ready = 1'b0;
    $display("frame sent bits=%0h n=%0d dout0=%0h dout1=%0h valid=%0b ovr=%0b perr=%0b cnt=%0d",
             bits, n, dout[0], dout[1], valid[0], ovr[0], perr[0], bcnt[0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    check("reset_data_out", int'(dout[0]), 0);
    check("reset_valid", int'(valid[0]), 0);
    check("reset_overrun", int'(ovr[0]), 0);
    check("reset_bit_count", int'(bcnt[0]), 0);
    rst = 1'b0;

`ifndef RX_DESER_PARITY_EN
    send(16'h004D, 8, 1'b0);
    check("lsb_word_4d", int'(dout[0]), 'h4D);
    check("msb_word_b2", int'(dout[1]), 'hB2);
    check("valid_after_frame", int'(valid[0]), 1);
    check("count_wrapped", int'(bcnt[0]), 0);
    idle(3);
    check("valid_held", int'(valid[0]), 1);

    send(16'h00FF, 8, 1'b0);
    check("dropped_keeps_4d", int'(dout[0]), 'h4D);
    check("overrun_set", int'(ovr[0]), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("overrun_cleared", int'(ovr[0]), 0);
    check("valid_after_clear", int'(valid[0]), 1);

    send(16'h000F, 8, 1'b1);
    check("accept_load_0f", int'(dout[0]), 'h0F);
    check("accept_load_msb_f0", int'(dout[1]), 'hF0);
    check("accept_load_valid", int'(valid[0]), 1);
    check("accept_load_no_ovr", int'(ovr[0]), 0);
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    check("consumed", int'(valid[0]), 0);
`else
    send(16'h0055, 8, 1'b0);
    check("par_word_55", int'(dout[0]), 'h55);
    check("par_even_ok", int'(perr[0]), 0);
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    send(16'h00D5, 8, 1'b0);
    check("par_word_55_b", int'(dout[0]), 'h55);
    check("par_even_bad", int'(perr[0]), 1);
    data_ready = 1'b1; tick(); data_ready = 1'b0;
`endif

    send(16'h0007, 3, 1'b0);
    idle(4);
    check("count_holds_idle", int'(bcnt[0]), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("count_after_rst", int'(bcnt[0]), 0);
    check("valid_after_rst", int'(valid[0]), 0);

`ifndef RX_DESER_PARITY_EN
    send(16'h00A5, 8, 1'b0);
    check("post_rst_a5", int'(dout[0]), 'hA5);
`else
    send(16'h00A5, 8, 1'b0);
    check("post_rst_25", int'(dout[0]), 'h25);
`endif
    check("post_rst_valid", int'(valid[0]), 1);
    data_ready = 1'b1; tick(); data_ready = 1'b0;

    send(16'h0001, 1, 1'b0);
    check("one_bit_count", int'(bcnt[0]), 1);
    shift = 1'b1; clear = 1'b1; serial_in = 1'b1;
    tick();
    shift = 1'b0; clear = 1'b0; serial_in = 1'b0;
    check("clear_beats_shift", int'(bcnt[0]), 0);
    send(16'h003C, 8, 1'b0);
    check("after_clear_lsb", int'(dout[0]), int'(assemble(16'h003C, 0)));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
